uart_msg_sequencer: RTL

Parametrised successor to the fixed-string button demo. Holds a writable message buffer of up to MAX_LEN characters and, on a debounced button press, streams the message byte-by-byte into the existing UART transmit controller through its send/ready handshake. Adds programmable length, single-shot or continuous-repeat mode, an inter-character gap and status outputs. Sits between board buttons/config logic and UART_TX_CTRL.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/uart_msg_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART message sequencer: sequencer state
// encoding, the default character width and common ASCII framing bytes.
package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4,
    ST_WAIT_RDY = 3'd5
  } seq_state_t;

  localparam logic [7:0] ASCII_SOH = 8'h01;
  localparam logic [7:0] ASCII_STX = 8'h02;
  localparam logic [7:0] ASCII_ETX = 8'h03;
  localparam logic [7:0] ASCII_EOT = 8'h04;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted low-to-high transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic start
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronise the button and accept a new level only once the synchronised
  // value has differed from the accepted one for DEBOUNCE_CYCLES cycles in a row;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b00;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], btn};
      level_d <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign start = level & ~level_d;

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams a programmable message buffer into UART_TX_CTRL over its
// send/ready handshake on each debounced button press, with optional
// continuous repeat and an idle gap after every accepted character.
module uart_msg_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int MAX_LEN         = 16,
  parameter int LEN_W           = $clog2(MAX_LEN + 1),
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int GAP_CYCLES      = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       BTN,
  input  logic                       CFG_WE,
  input  logic [$clog2(MAX_LEN)-1:0] CFG_ADDR,
  input  logic [DATA_W-1:0]          CFG_DATA,
  input  logic [LEN_W-1:0]           CFG_LEN,
  input  logic                       REPEAT,
  output logic                       TX_SEND,
  output logic [DATA_W-1:0]          TX_DATA,
  input  logic                       TX_READY,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [LEN_W-1:0]           CHAR_CNT
);

  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [ADDR_W:0]   ADDR_SPAN = (ADDR_W + 1)'(MAX_LEN);

  seq_state_t        state;
  seq_state_t        next_state;
  logic              start;
  logic [DATA_W-1:0] msg_buf [MAX_LEN];
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  char_cnt_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic              done_q;
  logic              latch_len;
  logic              start_run;
  logic              accept_char;
  logic              wrap_pass;
  logic              finish_run;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (CLK),
    .rst  (RST),
    .btn  (BTN),
    .start(start)
  );

  assign len_clamped = (CFG_LEN > MAX_LEN_V) ? MAX_LEN_V : CFG_LEN;

  // Message buffer writes are only honoured while idle and inside the buffer.
  always_ff @(posedge CLK) begin
    if (CFG_WE && (state == ST_IDLE) && ({1'b0, CFG_ADDR} < ADDR_SPAN)) begin
      msg_buf[CFG_ADDR] <= CFG_DATA;
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode; TX_SEND is only raised when the UART is ready.
  always_comb begin
    next_state  = state;
    TX_SEND     = 1'b0;
    latch_len   = 1'b0;
    start_run   = 1'b0;
    accept_char = 1'b0;
    wrap_pass   = 1'b0;
    finish_run  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch_len = 1'b1;
          if (len_clamped != '0) begin
            start_run  = 1'b1;
            next_state = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        next_state = ST_SEND;
      end
      ST_SEND: begin
        if (TX_READY) begin
          TX_SEND    = 1'b1;
          next_state = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!TX_READY) begin
          accept_char = 1'b1;
          next_state  = (GAP_CYCLES > 0) ? ST_GAP : ST_WAIT_RDY;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (TX_READY) begin
          if (idx < len_q) begin
            next_state = ST_LOAD;
          end else if (REPEAT) begin
            wrap_pass  = 1'b1;
            next_state = ST_LOAD;
          end else begin
            finish_run = 1'b1;
            next_state = ST_IDLE;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Run datapath: latched length, buffer index, pass counter, output character,
  // gap timer and the end-of-run pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q      <= '0;
      idx        <= '0;
      char_cnt_q <= '0;
      tx_data_q  <= '0;
      gap_cnt    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= finish_run;
      if (latch_len) begin
        len_q <= len_clamped;
      end
      if (start_run || wrap_pass) begin
        idx        <= '0;
        char_cnt_q <= '0;
      end else if (accept_char) begin
        idx        <= idx + LEN_W'(1);
        char_cnt_q <= char_cnt_q + LEN_W'(1);
      end
      if (state == ST_LOAD) begin
        tx_data_q <= msg_buf[idx[ADDR_W-1:0]];
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign TX_DATA  = tx_data_q;
  assign BUSY     = (state != ST_IDLE);
  assign DONE     = done_q;
  assign CHAR_CNT = char_cnt_q;

endmodule
